// File: rtl/key_pkg.sv
// Shared definitions for the key conditioner: per-key FSM state encoding and
// default debounce / auto-repeat cycle counts.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } key_state_t;

  localparam int DEF_DEB_CYCLES    = 1000000;
  localparam int DEF_REPEAT_DELAY  = 50000000;
  localparam int DEF_REPEAT_PERIOD = 10000000;

endpackage

// File: rtl/key_conditioner_if.sv
// Key conditioner signal bundle: raw key inputs, conditioned pulses/levels and
// per-key FSM state for observation. The master side drives the raw keys; the
// slave side (the conditioner) drives everything else. There is no handshake:
// pulses are single-cycle strobes and levels are plain debounced levels.
interface key_conditioner_if;
  import key_pkg::*;

  logic       button_raw;
  logic       pause_raw;
  logic       button;
  logic       pause;
  logic       button_level;
  logic       pause_level;
  key_state_t button_state;
  key_state_t pause_state;

  modport master (
    output button_raw, pause_raw,
    input  button, pause, button_level, pause_level, button_state, pause_state
  );

  modport slave (
    input  button_raw, pause_raw,
    output button, pause, button_level, pause_level, button_state, pause_state
  );

endinterface

// File: rtl/key_debounce.sv
// One key: two-flop synchronizer, 4-state debounce FSM with a saturating
// stable-cycle counter, registered one-cycle accept pulse and debounced level.
module key_debounce import key_pkg::*; #(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw,
  output logic       pulse,
  output logic       level,
  output key_state_t state
);

  localparam int            CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1, sync2;
  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept_d, accept_q;

  // Two-flop synchronizer for the asynchronous raw key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // State, counter and pulse registers; the accept flag is delayed one more
  // cycle so the pulse lands in the cycle after HELD has been entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      accept_q <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      accept_q <= accept_d;
      pulse    <= accept_q;
    end
  end

  // Next-state logic: DEB_CYCLES stable samples accept a press or a release.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2) begin
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          state_d  = HELD;
          accept_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!sync2) begin
          state_d = REL_WAIT;
          cnt_d   = '0;
        end
      end
      REL_WAIT: begin
        if (sync2) begin
          state_d = HELD;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level = (state_q == HELD) || (state_q == REL_WAIT);
  assign state = state_q;

endmodule

// File: rtl/key_conditioner.sv
// Key conditioner for the washer front panel: debounces the mode and
// start/pause keys independently and emits one-cycle press pulses.
// Optional feature macro: KEY_COND_REPEAT_EN adds auto-repeat on the mode key.
module key_conditioner import key_pkg::*; #(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input logic               clk,
  input logic               reset,
  key_conditioner_if.slave  keys
);

  logic       button_accept, pause_accept;
  logic       button_lvl, pause_lvl;
  key_state_t button_st, pause_st;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_button (
    .clk   (clk),
    .reset (reset),
    .raw   (keys.button_raw),
    .pulse (button_accept),
    .level (button_lvl),
    .state (button_st)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_pause (
    .clk   (clk),
    .reset (reset),
    .raw   (keys.pause_raw),
    .pulse (pause_accept),
    .level (pause_lvl),
    .state (pause_st)
  );

`ifdef KEY_COND_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_V  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] PERIOD_V = RW'(REPEAT_PERIOD);

  logic [RW-1:0] rep_cnt;
  logic          rep_first, rep_pulse, rep_hit;

  // First repeat waits REPEAT_DELAY held cycles, later ones REPEAT_PERIOD.
  assign rep_hit = (button_st == HELD) && (rep_cnt == (rep_first ? DELAY_V : PERIOD_V));

  // Repeat timer: cleared whenever the mode key is not in HELD, so every
  // entry to HELD (including a return from REL_WAIT) restarts the delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
      rep_pulse <= 1'b0;
    end else begin
      rep_pulse <= rep_hit;
      if (button_st != HELD) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end else if (rep_hit) begin
        rep_cnt   <= RW'(1);
        rep_first <= 1'b0;
      end else if (rep_cnt != '1) begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  assign keys.button = button_accept | rep_pulse;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
  assign keys.button = button_accept;
`endif

  assign keys.pause        = pause_accept;
  assign keys.button_level = button_lvl;
  assign keys.pause_level  = pause_lvl;
  assign keys.button_state = button_st;
  assign keys.pause_state  = pause_st;

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000, number of consecutive stable cycles required to accept a press or release.
REQ-002 Parameter REPEAT_DELAY, default 50000000, cycles a held mode key waits before its first auto-repeat pulse (used only with the macro in REQ-023).
REQ-003 Parameter REPEAT_PERIOD, default 10000000, cycles between later auto-repeat pulses (used only with the macro in REQ-023).
REQ-004 clk  input  1  system clock, single clock domain.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 button_raw  input  1  mode-select key, bouncing, asynchronous to clk, high = pressed.
REQ-007 pause_raw  input  1  start/pause key, bouncing, asynchronous to clk, high = pressed.
REQ-008 button  output  1  one-cycle accepted-press pulse for the washer controller button input.
REQ-009 pause  output  1  one-cycle accepted-press pulse for the washer controller pause input.
REQ-010 button_level  output  1  debounced level of the mode key.
REQ-011 pause_level  output  1  debounced level of the start/pause key.

Function
REQ-012 Each raw input SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-013 Each key SHALL have an independent 4-state FSM: IDLE, PRESS_WAIT, HELD, REL_WAIT.
REQ-014 IDLE: synced=1 -> PRESS_WAIT with counter cleared to 0; otherwise stay in IDLE.
REQ-015 PRESS_WAIT: synced=1 increments the counter; synced=0 -> IDLE; counter reaching DEB_CYCLES-1 with synced=1 -> HELD.
REQ-016 The pulse output SHALL be high for exactly the one cycle after the PRESS_WAIT->HELD transition, i.e. DEB_CYCLES+3 edges after the first synchronizer flop captures 1.
REQ-017 HELD: synced=0 -> REL_WAIT with counter cleared; REL_WAIT: synced=1 -> HELD with no new pulse; DEB_CYCLES consecutive low cycles -> IDLE.
REQ-018 The level output SHALL be 1 in HELD and REL_WAIT and 0 in IDLE and PRESS_WAIT.
REQ-019 Counter width SHALL be $clog2 of the largest enabled count parameter, and the counter SHALL saturate and never wrap.
REQ-020 The two keys SHALL be fully independent with no arbitration; coincident pulses on button and pause are legal.
REQ-021 A bounce shorter than DEB_CYCLES SHALL produce no pulse and no level change.

Reset
REQ-022 While reset=1, all FSMs SHALL be in IDLE, counters and synchronizer flops SHALL be 0, and all four outputs SHALL be 0; a key still held when reset is released SHALL be treated as a fresh press (one pulse after full debounce).

Configuration
REQ-023 With KEY_COND_REPEAT_EN defined: in HELD for the mode key only, a cycle counter SHALL emit a button pulse after REPEAT_DELAY held cycles, then every REPEAT_PERIOD cycles, and SHALL restart on every entry to HELD; pause SHALL never repeat.
REQ-024 Without KEY_COND_REPEAT_EN: exactly one pulse per accepted press, no repeat counter synthesized, and REPEAT_DELAY/REPEAT_PERIOD ignored.

Structure
REQ-025 The shared package key_pkg SHALL hold the FSM state enum (IDLE, PRESS_WAIT, HELD, REL_WAIT) and default debounce/repeat constants.
REQ-026 The per-key synchronizer, FSM and counter SHALL be the sub-module key_debounce, instantiated twice; repeat logic SHALL sit in key_conditioner.

Verification (DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-027 Clean press: button_raw held high for 20 cycles -> exactly one button pulse, 7 edges after first capture; button_level high until 4 stable low cycles after release.
REQ-028 Bounce: pause_raw toggles 1,0,1,0 at one-cycle intervals then stays 0 -> no pause pulse, pause_level stays 0.
REQ-029 Release bounce: from HELD, button_raw low for 2 cycles then high again -> level stays 1, no second pulse.
REQ-030 Simultaneous: both raw inputs rise on the same cycle -> button and pause pulse on the same cycle, once each.
REQ-031 Reset mid-press: reset asserted during PRESS_WAIT with button_raw=1 -> outputs 0 immediately; after reset is released with the key still held -> one pulse after full debounce.
REQ-032 Repeat, macro defined: button_raw held for 40 cycles -> pulses at acceptance, +10, +15, +20, ...; same stimulus without the macro -> one pulse.
